// File: rtl/nn_frame_driver_if.sv
// Bundle of the pixel-stream, classifier-core and result-stream signals of nn_frame_driver.
// The slave modport is the frame driver itself; master is whoever drives it.
interface nn_frame_driver_if #(
  parameter int PIXELS  = 784,
  parameter int CLASSES = 10,
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 4
);
  logic                       in_valid;
  logic                       in_pixel;
  logic                       in_ready;
  logic                       nn_start;
  logic [PIXELS-1:0]          nn_image;
  logic                       nn_finish;
  logic [SCORE_W*CLASSES-1:0] nn_scores;
  logic                       out_valid;
  logic                       out_ready;
  logic [IDX_W-1:0]           out_digit;
  logic [SCORE_W-1:0]         out_score;
  logic                       busy;

  modport slave (
    input  in_valid, in_pixel, nn_finish, nn_scores, out_ready,
    output in_ready, nn_start, nn_image, out_valid, out_digit, out_score, busy
  );

  modport master (
    output in_valid, in_pixel, nn_finish, nn_scores, out_ready,
    input  in_ready, nn_start, nn_image, out_valid, out_digit, out_score, busy
  );
endinterface

// File: rtl/nn_frame_driver.sv
// Loads a binarized image from a pixel stream, runs the classifier core once,
// then picks the highest class score with a one-class-per-cycle argmax.
module nn_frame_driver #(
  parameter int PIXELS  = 784,
  parameter int CLASSES = 10,
  parameter int SCORE_W = 32,
  parameter int IDX_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  nn_frame_driver_if.slave  bus
);
  localparam int PIX_W = $clog2(PIXELS);

  localparam logic [2:0] LOAD   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] ARGMAX = 3'd3;
  localparam logic [2:0] OUT    = 3'd4;

  logic [2:0]                state_reg;
  logic [PIX_W-1:0]          pix_cnt_reg;
  logic [PIXELS-1:0]         image_reg;
  logic signed [SCORE_W-1:0] score_buf [CLASSES];
  logic signed [SCORE_W-1:0] score_in  [CLASSES];
  logic [IDX_W-1:0]          k_reg;
  logic [IDX_W-1:0]          best_idx_reg;
  logic signed [SCORE_W-1:0] best_reg;
  logic [IDX_W-1:0]          digit_reg;
  logic signed [SCORE_W-1:0] score_reg;
  logic signed [SCORE_W-1:0] cur_score;
  logic                      take_k;
  logic                      last_k;
  logic                      capture;

  // Class 0 sits in the most significant slice of the core's score bus.
  generate
    for (genvar gi = 0; gi < CLASSES; gi++) begin : g_unpack
      assign score_in[gi] = bus.nn_scores[SCORE_W*(CLASSES-gi)-1 -: SCORE_W];
    end
  endgenerate

  assign capture   = (state_reg == WAIT) && bus.nn_finish;
  assign cur_score = score_buf[k_reg];
  assign last_k    = (k_reg == IDX_W'(CLASSES-1));
  // Strictly-greater compare keeps the lowest index on ties.
  assign take_k    = (k_reg == '0) || (cur_score > best_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CLASSES; i++) score_buf[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < CLASSES; i++) score_buf[i] <= score_in[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= LOAD;
      pix_cnt_reg  <= '0;
      image_reg    <= '0;
      k_reg        <= '0;
      best_idx_reg <= '0;
      best_reg     <= '0;
      digit_reg    <= '0;
      score_reg    <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (bus.in_valid) begin
            image_reg[PIX_W'(PIXELS-1) - pix_cnt_reg] <= bus.in_pixel;
            if (pix_cnt_reg == PIX_W'(PIXELS-1)) begin
              pix_cnt_reg <= '0;
              state_reg   <= START;
            end else begin
              pix_cnt_reg <= pix_cnt_reg + PIX_W'(1);
            end
          end
        end
        START: state_reg <= WAIT;
        WAIT: begin
          if (bus.nn_finish) begin
            k_reg     <= '0;
            state_reg <= ARGMAX;
          end
        end
        ARGMAX: begin
          if (take_k) begin
            best_reg     <= cur_score;
            best_idx_reg <= k_reg;
          end
          if (last_k) begin
            digit_reg <= take_k ? k_reg : best_idx_reg;
            score_reg <= take_k ? cur_score : best_reg;
            state_reg <= OUT;
          end else begin
            k_reg <= k_reg + IDX_W'(1);
          end
        end
        OUT: begin
          if (bus.out_ready) state_reg <= LOAD;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.nn_start  = (state_reg == START);
  assign bus.nn_image  = image_reg;
  assign bus.out_valid = (state_reg == OUT);
  assign bus.out_digit = digit_reg;
  assign bus.out_score = score_reg;
  assign bus.busy      = (state_reg != LOAD);
endmodule

// File: tb/tb_nn_frame_driver.sv
// Randomized bench for nn_frame_driver against a plain-arithmetic image and argmax model.
module tb_nn_frame_driver;
  localparam int PIXELS  = 784;
  localparam int CLASSES = 10;
  localparam int SCORE_W = 32;
  localparam int IDX_W   = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nn_frame_driver_if #(.PIXELS(PIXELS), .CLASSES(CLASSES), .SCORE_W(SCORE_W), .IDX_W(IDX_W)) bus ();

  nn_frame_driver #(.PIXELS(PIXELS), .CLASSES(CLASSES), .SCORE_W(SCORE_W), .IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  bit                pix_q [PIXELS];
  logic [PIXELS-1:0] exp_img;
  int                sc [CLASSES];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_image(input string tag);
    logic [PIXELS-1:0] o;
    logic [PIXELS-1:0] e;
    for (int s = 0; s * 64 < PIXELS; s++) begin
      o = bus.nn_image >> (s * 64);
      e = exp_img >> (s * 64);
      check($sformatf("%s_img%0d", tag, s), 64'(o), 64'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(bus.in_ready), 64'(1));
    check({tag, "_nn_start"},  64'(bus.nn_start), 64'(0));
    check({tag, "_image_any"}, 64'(|bus.nn_image), 64'(0));
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_out_digit"}, 64'(bus.out_digit), 64'(0));
    check({tag, "_out_score"}, 64'(bus.out_score), 64'(0));
    check({tag, "_busy"},      64'(bus.busy), 64'(0));
  endtask

  // Raster pixel i lands in image bit PIXELS-1-i.
  task automatic gen_pixels(input bit alternating);
    for (int i = 0; i < PIXELS; i++) begin
      pix_q[i] = alternating ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      exp_img[PIXELS-1-i] = pix_q[i];
    end
  endtask

  task automatic load_frame(input string tag, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < PIXELS && guard < 4 * PIXELS) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_pixel = pix_q[i];
      end
      if (bus.in_valid && bus.in_ready) i++;
    end
    check({tag, "_accepts"}, 64'(i), 64'(PIXELS));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check({tag, "_start_hi"}, 64'(bus.nn_start), 64'(1));
    check({tag, "_ready_lo"}, 64'(bus.in_ready), 64'(0));
    check({tag, "_busy_hi"},  64'(bus.busy), 64'(1));
    check_image(tag);
    @(negedge clk);
    check({tag, "_start_lo"}, 64'(bus.nn_start), 64'(0));
  endtask

  task automatic drive_scores();
    logic [SCORE_W*CLASSES-1:0] v;
    for (int k = 0; k < CLASSES; k++) v[SCORE_W*(CLASSES-k)-1 -: SCORE_W] = sc[k];
    bus.nn_scores = v;
  endtask

  function automatic int ref_argmax();
    int b = 0;
    for (int k = 1; k < CLASSES; k++) if (sc[k] > sc[b]) b = k;
    return b;
  endfunction

  // Waits a random core latency, pulses finish, then checks latency, result, hold and handshake.
  task automatic classify(input string tag, input bit spurious, input int hold);
    int cnt = 0;
    int exp_idx;
    logic [SCORE_W-1:0] exp_score;
    logic [IDX_W-1:0] d0;
    logic [SCORE_W-1:0] s0;
    bit stable = 1'b1;
    exp_idx   = ref_argmax();
    exp_score = sc[exp_idx];
    repeat ($urandom_range(0, 5)) begin
      @(negedge clk);
      if (spurious) bus.in_valid = 1'($urandom_range(0, 1));
      if (bus.in_ready) stable = 1'b0;
    end
    @(negedge clk);
    bus.nn_finish = 1'b1;
    drive_scores();
    do begin
      @(posedge clk);
      cnt++;
      #1;
      bus.nn_finish = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.nn_scores = {CLASSES{32'($urandom)}};
      if (spurious) bus.in_valid = 1'($urandom_range(0, 1));
      if (bus.in_ready && !bus.out_valid) stable = 1'b0;
    end while (!bus.out_valid && cnt < 40);
    check({tag, "_latency"}, 64'(cnt), 64'(CLASSES + 1));
    check({tag, "_digit"}, 64'(bus.out_digit), 64'(exp_idx));
    check({tag, "_score"}, 64'(bus.out_score), 64'(exp_score));
    d0 = bus.out_digit;
    s0 = bus.out_score;
    repeat (hold) begin
      @(negedge clk);
      if (spurious) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.nn_finish = 1'($urandom_range(0, 1));
      end
      if (!bus.out_valid || bus.in_ready || bus.out_digit !== d0 || bus.out_score !== s0)
        stable = 1'b0;
    end
    check({tag, "_hold_stable"}, 64'(stable), 64'(1));
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.nn_finish = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_back_load"}, 64'(bus.in_ready), 64'(1));
    // A finish pulse while loading must not restart the argmax.
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      bus.nn_finish = 1'b1;
      if (bus.out_valid || bus.busy) stable = 1'b0;
    end
    @(negedge clk);
    bus.nn_finish = 1'b0;
    if (bus.out_valid || bus.busy) stable = 1'b0;
    check({tag, "_no_rerun"}, 64'(stable), 64'(1));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pixel  = 1'b0;
    bus.nn_finish = 1'b0;
    bus.nn_scores = '0;
    bus.out_ready = 1'b0;
    exp_img       = '0;

    // Power-on reset, then a mid-load asynchronous reset that drops the partial frame.
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    gen_pixels(1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_pixel = 1'b1;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check({"post_rst", "_in_ready"}, 64'(bus.in_ready), 64'(1));

    // Alternating pattern; class 7 wins; backpressure with spurious inputs.
    gen_pixels(1'b1);
    load_frame("alt", 1'b0);
    check("alt_pattern", 64'(exp_img == {392{2'b10}}), 64'(1));
    for (int k = 0; k < CLASSES; k++) sc[k] = -100;
    sc[7] = 500;
    classify("c7", 1'b1, 5);

    // Tie at the positive extreme resolves to the lower index.
    gen_pixels(1'b0);
    load_frame("tie", 1'b0);
    for (int k = 0; k < CLASSES; k++) sc[k] = 0;
    sc[2] = 32'h7FFFFFFF;
    sc[5] = 32'h7FFFFFFF;
    classify("tie", 1'b0, 0);

    // All negative: the least negative (class 9 = -3) wins.
    gen_pixels(1'b0);
    load_frame("neg", 1'b1);
    for (int k = 0; k < CLASSES; k++) sc[k] = -1000 - 7 * k;
    sc[9] = -3;
    classify("neg", 1'b0, 2);

    // Reset while the argmax is at k = 4; the aborted frame must never produce a result.
    begin
      bit quiet = 1'b1;
      gen_pixels(1'b0);
      load_frame("abort", 1'b0);
      for (int k = 0; k < CLASSES; k++) sc[k] = k;
      @(negedge clk);
      bus.nn_finish = 1'b1;
      drive_scores();
      @(posedge clk);
      #1;
      bus.nn_finish = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("argrst");
      @(negedge clk);
      rst = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (bus.out_valid || !bus.in_ready) quiet = 1'b0;
      end
      check("abort_quiet", 64'(quiet), 64'(1));
    end
    gen_pixels(1'b0);
    load_frame("after", 1'b0);
    for (int k = 0; k < CLASSES; k++) sc[k] = int'($urandom_range(0, 1000)) - 2000;
    sc[3] = 77;
    classify("c3", 1'b0, 1);

    // Randomized frames: narrow score ranges provoke ties, wide ones exercise the sign.
    for (int f = 0; f < 5; f++) begin
      gen_pixels(1'b0);
      load_frame($sformatf("rnd%0d", f), f[0]);
      for (int k = 0; k < CLASSES; k++)
        sc[k] = f[0] ? int'($urandom_range(0, 6)) - 3 : int'($urandom);
      classify($sformatf("rnd%0d", f), f[1], int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/nn_frame_driver.md
# nn_frame_driver

Initiator-side companion to the neural-network classifier core. It collects a binarized 28x28 image as a pixel stream, presents it to the core as a 784-bit vector with a one-cycle start pulse, and waits for the core's finish pulse. It then captures the 10 signed class scores and runs a sequential argmax. The recognized digit and its score are delivered on a valid/ready output toward the sudoku board logic.

## Interface
Parameters:
- PIXELS, 784, image bits per frame; must match the core's input width.
- CLASSES, 10, number of class scores.
- SCORE_W, 32, width of each signed two's-complement score.
- IDX_W, 4, width of the digit index; must satisfy 2^IDX_W >= CLASSES.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; the block is in reset while rst == 0.
- in_valid  input  1  a pixel is offered.
- in_pixel  input  1  binarized pixel, raster order (row 0 col 0 first).
- in_ready  output  1  block accepts a pixel this cycle.
- nn_start  output  1  one-cycle start pulse to the core.
- nn_image  output  PIXELS  image vector to the core.
- nn_finish  input  1  core done pulse; scores are valid only in this cycle.
- nn_scores  input  SCORE_W*CLASSES  class scores; class k occupies bits [SCORE_W*(CLASSES-k)-1 -: SCORE_W], so class 0 is at the MSB slice.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_digit  output  IDX_W  argmax class index.
- out_score  output  SCORE_W  score of out_digit.
- busy  output  1  high in every state except LOAD.

## Operation
- States are LOAD, START, WAIT, ARGMAX and OUT. The block enters LOAD on reset.
- LOAD:
  - in_ready = 1.
  - Each accepted pixel (in_valid & in_ready) is written to nn_image bit PIXELS-1-pix_cnt, then pix_cnt increments.
  - When the accept with pix_cnt == PIXELS-1 occurs, pix_cnt returns to 0 and the state moves to START.
- START: nn_start = 1 for exactly this one cycle, then the state moves to WAIT.
- nn_image is held stable from the last pixel accept until the block returns to LOAD.
- WAIT: on the cycle nn_finish = 1, all of nn_scores is registered into an internal score buffer, k is cleared, and the state moves to ARGMAX.
- ARGMAX: one class is examined per cycle, k = 0..CLASSES-1.
  - At k = 0, best is loaded unconditionally with class 0.
  - For k > 0, best is replaced only if score[k] > best (signed, strictly greater), so ties resolve to the lowest index.
  - After k = CLASSES-1, out_digit and out_score are registered and the state moves to OUT.
- OUT:
  - out_valid = 1 and the outputs are held constant until out_ready = 1.
  - On the handshake cycle the state moves to LOAD, and out_valid is low on the next cycle.
- nn_finish is ignored in LOAD, START, ARGMAX and OUT.
- in_valid is ignored outside LOAD, because in_ready = 0 there.

## Timing
- Reset values: in_ready = 1, nn_start = 0, nn_image = 0, out_valid = 0, out_digit = 0, out_score = 0, busy = 0. pix_cnt, k and the score buffer are all cleared.
- Reset mid-operation: all outputs go to their reset values asynchronously, and any partially loaded frame is discarded. Reset of the core is the core's own responsibility.
- nn_start rises on the first edge after the final pixel accept.
- out_valid rises CLASSES+1 edges after the edge that samples nn_finish = 1: one edge for capture and CLASSES edges for the argmax.
- Minimum frame period is PIXELS + 1 + core latency + CLASSES + 2 cycles, with out_ready tied high.
- Throughput for in_valid held high is one pixel per cycle with no bubbles within a frame.

## Test plan
- Reset check:
  - Stimulus: drive rst = 0 mid-cycle, then release it.
  - Required response: all outputs hold their reset values, and in_ready = 1 on the first cycle after release.
- Frame load:
  - Stimulus: stream 784 pixels, alternating 1,0, starting with 1.
  - Required response: after the last accept, nn_image = {392{2'b10}}, nn_start is high for exactly 1 cycle on the next edge, and in_ready = 0 with busy = 1.
- Normal classification:
  - Stimulus: pulse nn_finish with scores = -100 for every class except class 7 = 500.
  - Required response: out_digit = 7 and out_score = 500, with out_valid exactly 11 edges after finish.
- Tie and all-negative cases:
  - Stimulus 1: classes 2 and 5 = 0x7FFFFFFF, all others 0. Required response: out_digit = 2.
  - Stimulus 2: all classes negative, with class 9 = -3 as the least negative. Required response: out_digit = 9 and out_score = 0xFFFFFFFD.
- Backpressure and spurious inputs:
  - Stimulus: hold out_ready = 0 for 5 cycles, toggle in_valid and nn_finish during WAIT/OUT, then assert out_ready.
  - Required response: outputs are stable while out_ready = 0, no pixel is accepted, and no rerun occurs. The block returns to LOAD after the handshake with pix_cnt = 0.
- Reset during ARGMAX:
  - Stimulus: assert rst at k = 4, release it, then run a full new frame with a class 3 maximum.
  - Required response: no out_valid is produced from the aborted frame, and the new frame yields out_digit = 3.
